complex_to_polar: RTL and testbench

COMPLEX_TO_POLAR -- requirements
Module: complex_to_polar

---
 rtl/complex_to_polar.sv | 137 +++++++++++++
 tb/tb_complex_to_polar.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/complex_to_polar.sv
`default_nettype none
// ============================================================================
// complex_to_polar : pipelined CORDIC vectoring, (re,im) -> 8-bit phase and
//                    saturated log2 magnitude code.          Rev 1.0
// ============================================================================
module complex_to_polar #(
   parameter int ITERATIONS = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        in_valid,
   input  logic [15:0] in_re,
   input  logic [15:0] in_im,
   output logic        out_valid,
   output logic [7:0]  phase,
   output logic [7:0]  log_mag
);

   localparam logic [15:0] C_ATAN [0:11] = '{
      16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326,
      16'd163,  16'd81,   16'd41,   16'd20,   16'd10,  16'd5
   };

   // Index 0 is the pre-rotation register, index k holds the result of CORDIC stage k-1.
   logic signed [17:0] r_x   [0:ITERATIONS];
   logic signed [17:0] r_y   [0:ITERATIONS];
   logic        [15:0] r_z   [0:ITERATIONS];
   logic               r_zf  [0:ITERATIONS];
   logic               r_vld [0:ITERATIONS];

   logic signed [17:0] w_re_ext;
   logic signed [17:0] w_im_ext;
   logic signed [17:0] w_x_pre;
   logic signed [17:0] w_y_pre;
   logic        [15:0] w_z_pre;

   assign w_re_ext = {{2{in_re[15]}}, in_re};
   assign w_im_ext = {{2{in_im[15]}}, in_im};

   // Fold the left half-plane onto the right so the CORDIC range covers it.
   always_comb begin
      w_x_pre = w_re_ext;
      w_y_pre = w_im_ext;
      w_z_pre = 16'h0000;
      if (w_re_ext[17]) begin
         w_x_pre = -w_re_ext;
         w_y_pre = -w_im_ext;
         w_z_pre = 16'h8000;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         r_x[0]  <= w_x_pre;
         r_y[0]  <= w_y_pre;
         r_z[0]  <= w_z_pre;
         r_zf[0] <= (in_re == 16'd0) && (in_im == 16'd0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld[0] <= 1'b0;
      end else if (en) begin
         r_vld[0] <= in_valid;
      end
   end

   for (genvar k = 0; k < ITERATIONS; k++) begin : g_cordic
      always_ff @(posedge clk) begin
         if (en) begin
            if (!r_y[k][17]) begin
               r_x[k+1] <= r_x[k] + (r_y[k] >>> k);
               r_y[k+1] <= r_y[k] - (r_x[k] >>> k);
               r_z[k+1] <= r_z[k] + C_ATAN[k];
            end else begin
               r_x[k+1] <= r_x[k] - (r_y[k] >>> k);
               r_y[k+1] <= r_y[k] + (r_x[k] >>> k);
               r_z[k+1] <= r_z[k] - C_ATAN[k];
            end
            r_zf[k+1] <= r_zf[k];
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_vld[k+1] <= 1'b0;
         end else if (en) begin
            r_vld[k+1] <= r_vld[k];
         end
      end
   end

   logic [17:0] w_mag;
   logic [4:0]  w_lead;
   logic [3:0]  w_frac;
   logic [8:0]  w_raw;
   logic [7:0]  w_log_code;
   logic [7:0]  w_unused_z_lsb;

   assign w_mag          = r_x[ITERATIONS];
   assign w_unused_z_lsb = r_z[ITERATIONS][7:0];

   // Piecewise-linear log2: leading-one position as integer part, next 4 bits as fraction.
   always_comb begin
      w_lead = 5'd0;
      for (int b = 0; b < 18; b++) begin
         if (w_mag[b]) begin
            w_lead = 5'(b);
         end
      end
      w_frac = 4'({w_mag, 4'b0000} >> w_lead);
      w_raw  = {w_lead, w_frac};
      if (r_zf[ITERATIONS] || (w_mag == 18'd0)) begin
         w_log_code = 8'h00;
      end else if (w_raw[8]) begin
         w_log_code = 8'hFF;
      end else begin
         w_log_code = w_raw[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         phase     <= 8'h00;
         log_mag   <= 8'h00;
      end else if (en) begin
         out_valid <= r_vld[ITERATIONS];
         phase     <= r_zf[ITERATIONS] ? 8'h00 : r_z[ITERATIONS][15:8];
         log_mag   <= w_log_code;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_complex_to_polar.sv
`default_nettype none
// tb_complex_to_polar : directed and randomized checks of complex_to_polar
// against an atan2 / log2 reference model with an enabled-cycle delay queue.
module tb_complex_to_polar;

   localparam int ITER = 12;
   localparam int LAT  = ITER + 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       in_valid;
   logic [15:0] in_re;
   logic [15:0] in_im;
   logic       out_valid;
   logic [7:0] phase;
   logic [7:0] log_mag;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit chk_on = 1'b0;
   real gain;

   typedef struct { bit v; int ph; int lg; } exp_t;
   exp_t q[$];
   exp_t cur;
   exp_t e_new;
   int   cmp_d;
   int   cmp_dl;

   complex_to_polar #(.ITERATIONS(ITER)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (in_valid),
      .in_re     (in_re),
      .in_im     (in_im),
      .out_valid (out_valid),
      .phase     (phase),
      .log_mag   (log_mag)
   );

   always #5 clk = ~clk;

   function automatic int model_phase(int re, int im);
      real t;
      if (re == 0 && im == 0) return 0;
      t = $atan2(real'(im), real'(re)) * 128.0 / 3.14159265358979;
      return int'($floor(t)) & 255;
   endfunction

   function automatic int model_log(int re, int im);
      real m;
      int  p;
      int  f;
      int  raw;
      if (re == 0 && im == 0) return 0;
      m = gain * $sqrt(real'(re) * real'(re) + real'(im) * real'(im));
      if (m < 1.0) return 0;
      p = int'($floor($ln(m) / $ln(2.0)));
      f = int'($floor((m / (2.0 ** p) - 1.0) * 16.0));
      if (f < 0) f = 0;
      if (f > 15) f = 15;
      raw = 16 * p + f;
      return (raw > 255) ? 255 : raw;
   endfunction

   // Reference: every enabled edge accepts one slot; a slot emerges LAT enabled edges later.
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         cur = '{1'b0, 0, 0};
      end else if (en) begin
         e_new.v  = in_valid;
         e_new.ph = model_phase($signed(in_re), $signed(in_im));
         e_new.lg = model_log($signed(in_re), $signed(in_im));
         q.push_back(e_new);
         if (q.size() == LAT) cur = q.pop_front();
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         tests++;
         if (out_valid !== cur.v) begin
            fails++;
            $display("FAIL out_valid cyc=%0d got %0b want %0b", cyc, out_valid, cur.v);
         end else if (cur.v) begin
            tests++;
            cmp_d = (int'(phase) - cur.ph) & 255;
            if (!(cmp_d == 0 || cmp_d == 1 || cmp_d == 255)) begin
               fails++;
               $display("FAIL phase cyc=%0d got %0d want %0d (+/-1)", cyc, phase, cur.ph);
            end
            tests++;
            cmp_dl = int'(log_mag) - cur.lg;
            if (cmp_dl > 1 || cmp_dl < -1) begin
               fails++;
               $display("FAIL log_mag cyc=%0d got %0d want %0d (+/-1)", cyc, log_mag, cur.lg);
            end
         end
      end
   end

   task automatic step(input bit e, input bit v, input int re, input int im);
      en       = e;
      in_valid = v;
      in_re    = 16'(re);
      in_im    = 16'(im);
      @(negedge clk);
      cyc++;
   endtask

   task automatic check_int(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic check_lit(input string name, input int ph_want, input int lg_want);
      int d;
      check_int({name, "_valid"}, int'(out_valid), 1);
      tests++;
      d = (int'(phase) - ph_want) & 255;
      if (!(d == 0 || d == 1 || d == 255)) begin
         fails++;
         $display("FAIL %s_phase got 0x%02h want 0x%02h (+/-1)", name, phase, ph_want);
      end
      tests++;
      d = int'(log_mag) - lg_want;
      if (d > 1 || d < -1) begin
         fails++;
         $display("FAIL %s_log got 0x%02h want 0x%02h (+/-1)", name, log_mag, lg_want);
      end
   endtask

   task automatic rand_pt(output int re, output int im);
      do begin
         re = int'($urandom_range(0, 65535)) - 32768;
         im = int'($urandom_range(0, 65535)) - 32768;
      end while (re * re + im * im < 1024 * 1024);
   endtask

   task automatic wait_out(input int t0, input string name, input int want_delay);
      while (!out_valid && (cyc - t0) < 80) step(1'b1, 1'b0, 0, 0);
      check_int(name, cyc - t0 + 1, want_delay);
   endtask

   initial begin
      int t0;
      int re;
      int im;
      gain = 1.0;
      for (int i = 0; i < ITER; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2 * i));

      rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;
      repeat (3) @(negedge clk);
      check_int("reset_out_valid", int'(out_valid), 0);
      check_int("reset_phase", int'(phase), 0);
      check_int("reset_log_mag", int'(log_mag), 0);
      rst = 1'b0;
      chk_on = 1'b1;

      check_int("model_log_1000", model_log(1000, 0), 8'hA9);
      check_int("model_phase_neg_re", model_phase(-32768, 0), 8'h80);
      check_int("model_log_sat", model_log(32767, 32767), 8'hFF);

      step(1, 1, 1000, 0);
      repeat (LAT - 1) step(1, 0, 0, 0);
      check_lit("re1000", 8'h00, 8'hA9);

      step(1, 1, 0, 1000);
      step(1, 1, -1000, 0);
      step(1, 1, 0, -1000);
      repeat (LAT - 3) step(1, 0, 0, 0);
      check_lit("im_pos", 8'h40, 8'hA9);
      step(1, 0, 0, 0);
      check_lit("re_neg", 8'h80, 8'hA9);
      step(1, 0, 0, 0);
      check_lit("im_neg", 8'hC0, 8'hA9);

      step(1, 1, 0, 0);
      step(1, 1, 32767, 32767);
      step(1, 1, -32768, 0);
      repeat (LAT - 3) step(1, 0, 0, 0);
      check_lit("zero", 8'h00, 8'h00);
      step(1, 0, 0, 0);
      check_lit("max_diag", 8'h20, 8'hFF);
      step(1, 0, 0, 0);
      check_lit("min_re", 8'h80, 8'hFA);

      step(1, 1, 3000, -2000);
      t0 = cyc;
      step(1, 1, -1500, 2500);
      repeat (3) step(0, 1, 777, -777);
      step(1, 1, 20000, 7000);
      step(1, 1, -9000, -9000);
      step(1, 1, 1234, -30000);
      wait_out(t0, "stall_delay", LAT + 3);
      repeat (LAT + 4) step(1, 0, 0, 0);

      for (int n = 0; n < 6; n++) begin
         rand_pt(re, im);
         step(1, 1, re, im);
      end
      rst = 1'b1;
      step(0, 1, 5000, 5000);
      rst = 1'b0;
      check_int("rst_out_valid", int'(out_valid), 0);
      check_int("rst_phase", int'(phase), 0);
      check_int("rst_log_mag", int'(log_mag), 0);
      step(1, 1, 2000, 2000);
      t0 = cyc;
      wait_out(t0, "post_rst_delay", LAT);
      check_lit("post_rst", 8'h20, model_log(2000, 2000));

      for (int n = 0; n < 10000; n++) begin
         rand_pt(re, im);
         step($urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0, re, im);
      end
      repeat (LAT + 2) step(1, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #5_000_000;
      fails++;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
